enc8to3_scan: RTL
=================

ENC8TO3_SCAN -- requirements
Module: enc8to3_scan

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0; 0 = emit lowest set index first, 1 = highest first.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port en  input  1  enable; gates acceptance of new vectors only.
REQ-005 SHALL have port in  input  8  request vector; bit i set = emit code i.
REQ-006 SHALL have port in_valid  input  1  in holds a vector to accept.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector this cycle.
REQ-008 SHALL have port out  output  3  binary code of the current set bit.
REQ-009 SHALL have port out_valid  output  1  out holds a valid code.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out this cycle.
REQ-011 SHALL have port out_last  output  1  current code is the final one of the vector.
REQ-012 SHALL have port err_zero  output  1  one-cycle pulse: all-zero vector accepted.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, SCAN; pending register pend[7:0].
REQ-014 SHALL drive in_ready = 1 only in IDLE with en = 1; 0 in SCAN.
REQ-015 SHALL accept on a rising edge with in_valid && in_ready; in is sampled at that edge only.
REQ-016 SHALL, on acceptance of nonzero in, load pend = in, go to SCAN; out_valid = 1 from the next cycle (1-cycle latency).
REQ-017 SHALL, on acceptance of in = 8'h00, stay in IDLE, leave pend = 0, set err_zero = 1 for exactly the next cycle, never assert out_valid.
REQ-018 SHALL drive out_valid = 1 throughout SCAN and 0 in IDLE.
REQ-019 SHALL drive out = index of lowest set bit of pend (MSB_FIRST=0) or highest set bit (MSB_FIRST=1); out = 3'd0 in IDLE.
REQ-020 SHALL drive out_last = 1 iff out_valid and pend has exactly one bit set.
REQ-021 SHALL, on transfer (out_valid && out_ready), clear the pend bit at index out; if out_last, return to IDLE.
REQ-022 SHALL hold out, out_valid, out_last stable while out_valid && !out_ready.
REQ-023 SHALL sustain one code per cycle with out_ready held 1; a vector with N set bits occupies SCAN for exactly N cycles.
REQ-024 SHALL re-accept no earlier than the cycle after returning to IDLE (no same-edge accept on last transfer).
REQ-025 SHALL ignore en while in SCAN; an in-progress scan completes regardless of en.
REQ-026 SHALL ignore in and in_valid while in SCAN.

Reset
REQ-027 SHALL, while rst_n = 0, force state = IDLE, pend = 0, out = 0, out_valid = 0, out_last = 0, err_zero = 0, independent of clk.
REQ-028 SHALL abort any scan on reset mid-operation; no residual codes emitted after rst_n rises.
REQ-029 SHALL accept a new vector on the first rising edge after rst_n = 1 with en && in_valid.

Verification
REQ-030 SHALL verify: MSB_FIRST=0, in = 8'b1010_0100, out_ready = 1 -> out = 2, 5, 7 on 3 consecutive cycles, out_last only with 7, then IDLE, in_ready = 1.
REQ-031 SHALL verify: in = 8'b0001_0010, out_ready = 0 for 3 cycles then 1 -> out held at 1 (out_valid = 1) for 4 cycles, then 4 with out_last = 1.
REQ-032 SHALL verify: in = 8'h00 accepted -> err_zero = 1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-033 SHALL verify: in = 8'hF0 accepted, rst_n pulsed low after first transfer -> out_valid = 0 immediately, no further codes; next accept of 8'h01 yields out = 0 with out_last = 1.
REQ-034 SHALL verify: MSB_FIRST=1, in = 8'hFF -> out = 7..0 over 8 cycles, out_last only with 0.
REQ-035 SHALL verify: en = 0, in_valid = 1, in = 8'h08 -> in_ready = 0, out_valid stays 0; en raised -> out = 3 one cycle after acceptance.

Source files
------------

// File: rtl/enc8to3_scan.sv
// enc8to3_scan: accepts an 8-bit request vector and emits the index of each set bit, one code per transfer.
module enc8to3_scan #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       err_zero
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state, state_nxt;
    logic [7:0] pend, pend_nxt;
    logic       zero_nxt;
    logic [2:0] idx;

    assign in_ready  = (state == IDLE) && en;
    assign out_valid = (state == SCAN);
    assign out       = out_valid ? idx : 3'd0;
    assign out_last  = out_valid && $onehot(pend);

    // Select the next pending index; the last match in loop order wins.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (MSB_FIRST) begin
                if (pend[i]) idx = 3'(i);
            end else begin
                if (pend[7-i]) idx = 3'(7 - i);
            end
        end
    end

    // Next-state: accept in IDLE, retire one pending bit per transfer in SCAN.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        zero_nxt  = 1'b0;
        if (state == IDLE) begin
            if (in_valid && en) begin
                if (in != 8'h00) begin
                    pend_nxt  = in;
                    state_nxt = SCAN;
                end else begin
                    zero_nxt = 1'b1;
                end
            end
        end else if (out_ready) begin
            pend_nxt = pend & ~(8'd1 << idx);
            if (out_last) state_nxt = IDLE;
        end
    end

    // State, pending bits and the zero-vector pulse, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= 8'h00;
            err_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            err_zero <= zero_nxt;
        end
    end
endmodule
